// File: rtl/sum_accumulator.sv
// Accumulates N adder results ({cout,sum}, 0..15) into an ACC_W-bit total and
// presents it with a sticky overflow flag on a valid/ready output port.
module sum_accumulator #(
  parameter int ACC_W = 8,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  logic [ACC_W-1:0] w_v;
  logic [ACC_W:0]   w_sum;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_v       = ACC_W'({in_cout, in_sum});
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_v};
  assign w_cnt_nxt = r_cnt + CW'(1);

  // Handshake outputs depend on registered state only.
  assign in_ready  = (r_state != S_DONE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_acc   <= w_v;
          r_cnt   <= CW'(1);
          r_ovf   <= 1'b0;
          r_state <= (N == 1) ? S_DONE : S_ACC;
        end
        S_ACC: if (in_valid) begin
          r_acc <= w_sum[ACC_W-1:0];
          r_ovf <= r_ovf | w_sum[ACC_W];
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == CW'(N)) r_state <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_state <= S_IDLE;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: three instances (8b/N=4, 4b/N=2, 8b/N=1) share
// stimulus and are checked against an unbounded-sum frame model.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, in_cout, out_ready;
  logic [2:0] in_sum;

  logic       a_in_ready, a_out_valid, a_out_ovf, a_busy;
  logic [7:0] a_out_acc;
  logic       b_in_ready, b_out_valid, b_out_ovf, b_busy;
  logic [3:0] b_out_acc;
  logic       c_in_ready, c_out_valid, c_out_ovf, c_busy;
  logic [7:0] c_out_acc;

  int ntests = 0;
  int nfail  = 0;

  int Nm[3] = '{4, 2, 1};
  int Wm[3] = '{8, 4, 8};
  int mcnt[3];
  int msum[3];

  always #5 clk = ~clk;

  sum_accumulator #(.ACC_W(8), .N(4)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_acc(a_out_acc), .out_ovf(a_out_ovf), .busy(a_busy));

  sum_accumulator #(.ACC_W(4), .N(2)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_acc(b_out_acc), .out_ovf(b_out_ovf), .busy(b_busy));

  sum_accumulator #(.ACC_W(8), .N(1)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_acc(c_out_acc), .out_ovf(c_out_ovf), .busy(c_busy));

  // Observed outputs packed as {valid, ready, busy, ovf, acc[7:0]}.
  function automatic logic [11:0] obs(int k);
    case (k)
      0:       return {a_out_valid, a_in_ready, a_busy, a_out_ovf, a_out_acc};
      1:       return {b_out_valid, b_in_ready, b_busy, b_out_ovf, 4'h0, b_out_acc};
      default: return {c_out_valid, c_in_ready, c_busy, c_out_ovf, c_out_acc};
    endcase
  endfunction

  // The frame total is the plain sum of beats; it wrapped iff it reached 2^W.
  function automatic logic [11:0] expv(int k);
    int m;
    logic [7:0] acc;
    m   = 1 << Wm[k];
    acc = 8'(msum[k] % m);
    return {mcnt[k] == Nm[k], mcnt[k] < Nm[k], mcnt[k] > 0, msum[k] >= m, acc};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin mcnt[k] = 0; msum[k] = 0; end
  endtask

  task automatic drive(input logic valid, input logic [3:0] v);
    in_valid = valid;
    in_cout  = v[3];
    in_sum   = v[2:0];
  endtask

  // One clock: decide each model's event from pre-edge inputs, then sample at +1.
  task automatic tick();
    int nc[3];
    int ns[3];
    int v;
    v = {in_cout, in_sum};
    for (int k = 0; k < 3; k++) begin
      nc[k] = mcnt[k]; ns[k] = msum[k];
      if (clr) begin nc[k] = 0; ns[k] = 0; end
      else if (mcnt[k] == Nm[k]) begin
        if (out_ready) begin nc[k] = 0; ns[k] = 0; end
      end else if (in_valid) begin
        nc[k] = mcnt[k] + 1; ns[k] = msum[k] + v;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin mcnt[k] = nc[k]; msum[k] = ns[k]; end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'h0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ntests++;
      if (obs(k) !== 12'h400) begin
        nfail++; $display("FAIL reset[%0d] got %h want %h", k, obs(k), 12'h400);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] beats[4] = '{4'h3, 4'h5, 4'h7, 4'hE};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, beats[i]);
      tick();
      if (i == 2) begin
        ntests++;
        if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL basic_early_valid got %b want 0", a_out_valid); end
      end
    end
    drive(1'b0, 4'h0);
    ntests++;
    if ({a_out_valid, a_out_ovf, a_out_acc} !== {1'b1, 1'b0, 8'h1D}) begin
      nfail++; $display("FAIL basic_total got v=%b o=%b acc=%h want v=1 o=0 acc=1d", a_out_valid, a_out_ovf, a_out_acc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ntests++;
    if ({a_busy, a_out_valid, a_in_ready} !== 3'b001) begin
      nfail++; $display("FAIL basic_idle got busy=%b v=%b r=%b want 0 0 1", a_busy, a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1'b1, 4'hF); tick();
    drive(1'b1, 4'hF); tick();
    drive(1'b0, 4'h0);
    ntests++;
    if ({b_out_valid, b_out_ovf, b_out_acc} !== {1'b1, 1'b1, 4'hE}) begin
      nfail++; $display("FAIL ovf_total got v=%b o=%b acc=%h want v=1 o=1 acc=e", b_out_valid, b_out_ovf, b_out_acc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ntests++;
    if ({b_out_valid, b_out_ovf} !== 2'b00) begin
      nfail++; $display("FAIL ovf_clear got v=%b o=%b want 0 0", b_out_valid, b_out_ovf);
    end
  endtask

  task automatic test_backpressure();
    logic pat[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(pat[i], 4'h1);
      tick();
      ntests++;
      if (obs(0) !== expv(0)) begin nfail++; $display("FAIL bp_beat%0d got %h want %h", i, obs(0), expv(0)); end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'h1);
      tick();
      ntests++;
      if ({a_out_valid, a_in_ready, a_out_acc} !== {1'b1, 1'b0, 8'd4}) begin
        nfail++; $display("FAIL bp_hold%0d got v=%b r=%b acc=%h want 1 0 04", i, a_out_valid, a_in_ready, a_out_acc);
      end
    end
    drive(1'b0, 4'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    drive(1'b1, 4'h7); tick(); drive(1'b0, 4'h0);
    ntests++;
    if ({a_busy, a_out_acc} !== {1'b1, 8'd7}) begin
      nfail++; $display("FAIL bp_next got busy=%b acc=%h want 1 07", a_busy, a_out_acc);
    end
  endtask

  task automatic test_abort();
    do_reset();
    drive(1'b1, 4'h9); tick();
    drive(1'b1, 4'h9); tick();
    drive(1'b1, 4'h5); clr = 1'b1;
    ntests++;
    if (a_in_ready !== 1'b1) begin nfail++; $display("FAIL abort_ready got %b want 1", a_in_ready); end
    tick();
    clr = 1'b0; drive(1'b0, 4'h0);
    ntests++;
    if ({a_busy, a_in_ready, a_out_acc} !== {1'b0, 1'b1, 8'd0}) begin
      nfail++; $display("FAIL abort_idle got busy=%b r=%b acc=%h want 0 1 00", a_busy, a_in_ready, a_out_acc);
    end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 4'h2); tick(); end
    drive(1'b0, 4'h0);
    ntests++;
    if ({a_out_valid, a_out_acc} !== {1'b1, 8'd8}) begin
      nfail++; $display("FAIL abort_fresh got v=%b acc=%h want 1 08", a_out_valid, a_out_acc);
    end
  endtask

  task automatic test_reset_mid_n1();
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 4'h3); tick(); end
    drive(1'b0, 4'h0);
    #2 rst = 1'b1;
    model_clear();
    #1;
    ntests++;
    if (obs(0) !== 12'h400) begin nfail++; $display("FAIL rst_mid got %h want %h", obs(0), 12'h400); end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      ntests++;
      if (a_out_valid !== 1'b0) begin nfail++; $display("FAIL rst_no_valid%0d got %b want 0", i, a_out_valid); end
    end
    drive(1'b1, 4'hD); tick(); drive(1'b0, 4'h0);
    ntests++;
    if ({c_out_valid, c_out_acc} !== {1'b1, 8'd13}) begin
      nfail++; $display("FAIL n1_total got v=%b acc=%h want 1 0d", c_out_valid, c_out_acc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom));
      out_ready = $urandom_range(0, 1) == 1;
      clr       = $urandom_range(0, 31) == 0;
      tick();
      for (int k = 0; k < 3; k++) begin
        ntests++;
        if (obs(k) !== expv(k)) begin
          nfail++; $display("FAIL rand[%0d] cyc %0d got %h want %h", k, i, obs(k), expv(k));
        end
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_abort();
    test_reset_mid_n1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Sequential stage directly downstream of the 3-bit ripple adder. Each accepted beat takes the adder's 3-bit sum and carry-out as one 4-bit value (0..15) and adds it into a wider running accumulator. After N beats it presents the frame total, plus a sticky overflow flag, on a valid/ready output port. Valid/ready handshakes on both sides let the adder's operand source and the result consumer stall independently.

## Interface
- ACC_W, 8, accumulator and result width in bits. Legal range ACC_W >= 4.
- N, 4, beats per frame. Legal range N >= 1.

- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous frame abort.
- in_valid  in  1  an adder result is presented.
- in_ready  out  1  block can accept a beat.
- in_sum  in  3  adder sum S.
- in_cout  in  1  adder carry-out Cout.
- out_valid  out  1  frame total is available.
- out_ready  in  1  consumer accepts the total.
- out_acc  out  ACC_W  accumulator register.
- out_ovf  out  1  sticky overflow for the current frame.
- busy  out  1  a frame is in progress (state ACC or DONE).

## Operation
- **Beat value:** v = {in_cout, in_sum}, zero-extended to ACC_W bits.
- **Input handshake:** a beat is accepted on a rising edge where in_valid && in_ready. in_sum and in_cout are ignored when no beat is accepted.
- **Beat counter:** cnt, width clog2(N+1).

FSM states:
- **IDLE**
  - in_ready=1, out_valid=0, busy=0.
  - On accept: acc<=v, cnt<=1, ovf<=0. If N==1 go to DONE, else go to ACC.
- **ACC**
  - in_ready=1, out_valid=0, busy=1.
  - On accept: acc <= (acc+v) mod 2^ACC_W, and ovf <= ovf | carry out of bit ACC_W-1. cnt <= cnt+1.
  - When the accepted beat makes cnt==N, go to DONE.
- **DONE**
  - in_ready=0, out_valid=1, busy=1. out_acc and out_ovf are held stable.
  - On out_valid && out_ready, go to IDLE. acc, cnt and ovf are cleared to 0 on the same edge.

Other rules:
- out_acc always shows the acc register. It is meaningful only while out_valid=1.
- **clr:** sampled on a clock edge, it overrides every other event.
  - Next state is IDLE; acc, cnt and ovf become 0.
  - Any beat presented in that cycle is not accepted.
  - A pending output is discarded.
- **Simultaneous in_valid and clr:** the beat is dropped, but in_ready still shows its state-based value in that cycle.
- **Gaps:** in_valid=0 in ACC holds all state indefinitely.
- **Wrap-around:** the accumulator wraps modulo 2^ACC_W. ovf is set and stays set until the frame is consumed, clr, or rst.
- **Reset values:** state=IDLE, acc=0, cnt=0, ovf=0. Therefore out_acc=0, out_ovf=0, out_valid=0, in_ready=1, busy=0.
- **Reset mid-frame:** all state is discarded immediately. No partial total is ever presented.

## Timing
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Latency: out_valid rises on the edge that accepts beat N. The total is visible in the following cycle.
- Throughput: the minimum frame period is N+1 cycles (N accept cycles plus one DONE cycle with out_ready=1). A beat offered in the cycle right after DONE is accepted as beat 1 of the next frame.
- Backpressure: while in DONE with out_ready=0, out_valid, out_acc and out_ovf stay constant and in_ready stays 0.
- rst takes effect asynchronously. Its deassertion is assumed synchronous to clk at the system level.

## Test plan
1. **Basic frame.** ACC_W=8, N=4. Beats {C,S} = 0/011, 0/101, 0/111, 1/110 (v = 3, 5, 7, 14) on consecutive cycles. Then: out_valid=1 one cycle after beat 4, out_acc=8'h1D, out_ovf=0; IDLE follows after out_ready=1.
2. **Overflow.** ACC_W=4, N=2. Beats v=15 and v=15. Then: out_acc=4'hE, out_ovf=1, and out_ovf clears after the output is consumed.
3. **Backpressure plus gaps.** ACC_W=8, N=4, all beats v=1, with in_valid low for 2 cycles between beats 2 and 3. Hold out_ready=0 for 5 cycles after out_valid. Then:
   - out_acc=4 stays stable throughout.
   - in_ready=0, and any in_valid offered is not counted.
   - The next frame, after the handshake, starts with acc=v of its first beat.
4. **Abort.** ACC_W=8, N=4. Accept 2 beats (v=9, 9), then assert clr together with in_valid and v=5. Then: IDLE next cycle, out_acc=0, the v=5 beat is dropped, and a fresh 4-beat frame of v=2 gives out_acc=8.
5. **Reset mid-frame and N=1.** Assert rst after 3 beats: outputs go to their reset values immediately and no out_valid appears. Then with N=1, a beat v=13 gives out_valid with out_acc=13 on the next cycle.
